// File: rtl/aes_column_sequencer_pkg.sv
// aes_pkg: shared FSM states, byte indexing and (Inv)ShiftRows permutations
package aes_pkg;

  typedef enum logic [1:0] {IDLE, MIX, DONE} fsm_e;

  function automatic int byte_lsb(input int r, input int c);
    return 120 - 8 * (4 * c + r);
  endfunction

  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        o[byte_lsb(r, c) +: 8] = s[byte_lsb(r, (c + r) % 4) +: 8];
    return o;
  endfunction

  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        o[byte_lsb(r, c) +: 8] = s[byte_lsb(r, (c + 4 - r) % 4) +: 8];
    return o;
  endfunction

endpackage

// File: rtl/aes_mixcolumns_32bit.sv
// aes_mixcolumns_32bit: combinational MixColumns / InvMixColumns on one column
module aes_mixcolumns_32bit (
  input  logic [31:0] data_in,
  input  logic        enc_dec,
  output logic [31:0] data_out
);

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] b, input logic [3:0] k);
    logic [7:0] p2, p4, p8;
    p2 = xtime(b);
    p4 = xtime(p2);
    p8 = xtime(p4);
    return (k[0] ? b : 8'h00) ^ (k[1] ? p2 : 8'h00) ^ (k[2] ? p4 : 8'h00) ^ (k[3] ? p8 : 8'h00);
  endfunction

  for (genvar i = 0; i < 4; i++) begin : g_row
    logic [7:0] a0, a1, a2, a3;
    assign a0 = data_in[31 - 8 * i -: 8];
    assign a1 = data_in[31 - 8 * ((i + 1) % 4) -: 8];
    assign a2 = data_in[31 - 8 * ((i + 2) % 4) -: 8];
    assign a3 = data_in[31 - 8 * ((i + 3) % 4) -: 8];
    assign data_out[31 - 8 * i -: 8] = enc_dec
      ? gmul(a0, 4'd2) ^ gmul(a1, 4'd3) ^ a2 ^ a3
      : gmul(a0, 4'd14) ^ gmul(a1, 4'd11) ^ gmul(a2, 4'd13) ^ gmul(a3, 4'd9);
  end

endmodule

// File: rtl/aes_column_sequencer.sv
// aes_column_sequencer: column-serial (Inv)ShiftRows + (Inv)MixColumns round stage
module aes_column_sequencer
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  input  logic         in_enc_dec,
  input  logic         in_skip_mix,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state
);

  fsm_e         fsm_q;
  logic [127:0] state_q;
  logic [1:0]   col_q;
  logic         enc_q;
  logic         out_valid_q;
  logic [31:0]  col_in, col_out;

  assign in_ready  = (fsm_q == IDLE) | ((fsm_q == DONE) & out_ready);
  assign out_valid = out_valid_q;
  assign col_in    = state_q[{~col_q, 5'b0} +: 32];
  assign out_state = enc_q ? state_q : inv_shift_rows(state_q);

  aes_mixcolumns_32bit u_mix (
    .data_in (col_in),
    .enc_dec (enc_q),
    .data_out(col_out)
  );

  // capture, column write-back sweep and output handshake
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_q       <= IDLE;
      state_q     <= '0;
      col_q       <= '0;
      enc_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else if (fsm_q == MIX) begin
      state_q[{~col_q, 5'b0} +: 32] <= col_out;
      col_q <= col_q + 2'd1;
      if (col_q == 2'd3) begin
        fsm_q       <= DONE;
        out_valid_q <= 1'b1;
      end
    end else if (in_valid && in_ready) begin
      state_q     <= in_enc_dec ? shift_rows(in_state) : in_state;
      enc_q       <= in_enc_dec;
      col_q       <= '0;
      fsm_q       <= in_skip_mix ? DONE : MIX;
      out_valid_q <= in_skip_mix;
    end else if (fsm_q == DONE && out_ready) begin
      fsm_q       <= IDLE;
      out_valid_q <= 1'b0;
    end
  end

endmodule
